// File: rtl/cnt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnt_arb_pkg
// Description : Shared opcodes, FSM state encoding and counter width for the
//               arbitrated counter controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cnt_arb_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : cnt_arb_pkg
`default_nettype wire

// File: rtl/cnt_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_core
// Description : Counter datapath with synchronous clear, load and up/down
//               step; wraps modulo 2**CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_core
    import cnt_arb_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= '0;
        end else if (sclr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= din;
        end else if (en) begin
            r_count <= up ? (r_count + 1'b1) : (r_count - 1'b1);
        end
    end

    assign count = r_count;

endmodule : cnt_core
`default_nettype wire

// File: rtl/cnt_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cnt_arb_ctrl
// Description : Round-robin arbiter for two requesters sharing one counter.
//               Define CNT_ARB_SAT_EN to saturate at 0/15 with sticky ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_arb_ctrl
    import cnt_arb_pkg::*;
(
    input  logic             clk,
    input  logic             clr_n,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [1:0]       op_a,
    input  logic [1:0]       op_b,
    input  logic [CNT_W-1:0] val_a,
    input  logic [CNT_W-1:0] val_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             done,
    output logic             owner,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    state_t           r_state;
    logic [1:0]       r_op_q;
    logic [CNT_W-1:0] r_rem;
    logic             r_last;

    logic w_exec;
    logic w_is_step;
    logic w_step;
    logic w_up;
    logic w_load;
    logic w_sclr;
    logic w_en;
    logic w_win;

    assign w_exec    = (r_state == ST_EXEC);
    assign w_is_step = (r_op_q == OP_UP) || (r_op_q == OP_DOWN);
    assign w_step    = w_exec && w_is_step && (r_rem != '0);
    assign w_up      = (r_op_q == OP_UP);
    assign w_load    = w_exec && (r_op_q == OP_LOAD);
    assign w_sclr    = w_exec && (r_op_q == OP_CLEAR);

    // B wins when alone, or on a tie when A was granted last.
    assign w_win     = req_b && (!req_a || !r_last);

`ifdef CNT_ARB_SAT_EN
    logic w_wrap;
    logic r_ovf;

    assign w_wrap = w_step && (w_up ? (count == {CNT_W{1'b1}}) : (count == '0));
    assign w_en   = w_step && !w_wrap;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (w_sclr) begin
            r_ovf <= 1'b0;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_en = w_step;
    assign ovf  = 1'b0;
`endif

    // The latched val doubles as LOAD data and as the remaining step count.
    cnt_core u_cnt_core (
        .clk   (clk),
        .clr_n (clr_n),
        .sclr  (w_sclr),
        .load  (w_load),
        .en    (w_en),
        .up    (w_up),
        .din   (r_rem),
        .count (count)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_op_q  <= OP_LOAD;
            r_rem   <= '0;
            r_last  <= 1'b1;
            gnt_a   <= 1'b0;
            gnt_b   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b0;
            owner   <= 1'b0;
        end else begin
            gnt_a <= 1'b0;
            gnt_b <= 1'b0;
            done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_a || req_b) begin
                        r_op_q  <= w_win ? op_b : op_a;
                        r_rem   <= w_win ? val_b : val_a;
                        owner   <= w_win;
                        r_last  <= w_win;
                        gnt_a   <= !w_win;
                        gnt_b   <= w_win;
                        busy    <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_is_step && (r_rem != '0)) begin
                        r_rem <= r_rem - 1'b1;
                    end else begin
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : cnt_arb_ctrl
`default_nettype wire

// File: tb/tb_cnt_arb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_arb_ctrl
// Description : Self-checking bench for cnt_arb_ctrl against a transaction
//               level model of counter value, grant order and timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_arb_ctrl;
    import cnt_arb_pkg::*;

    logic       clk   = 1'b0;
    logic       clr_n = 1'b0;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic [1:0] op_a  = 2'b00;
    logic [1:0] op_b  = 2'b00;
    logic [3:0] val_a = 4'd0;
    logic [3:0] val_b = 4'd0;
    logic       gnt_a, gnt_b, done, owner, busy, ovf;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_count = 0;
    int m_last  = 1;
    int m_ovf   = 0;

    always #5 clk = ~clk;

    cnt_arb_ctrl dut (
        .clk   (clk),
        .clr_n (clr_n),
        .req_a (req_a),
        .req_b (req_b),
        .op_a  (op_a),
        .op_b  (op_b),
        .val_a (val_a),
        .val_b (val_b),
        .gnt_a (gnt_a),
        .gnt_b (gnt_b),
        .done  (done),
        .owner (owner),
        .busy  (busy),
        .count (count),
        .ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic void m_step(input bit up);
`ifdef CNT_ARB_SAT_EN
        if ((up && m_count == 15) || (!up && m_count == 0))
            m_ovf = 1;
        else
            m_count = up ? m_count + 1 : m_count - 1;
`else
        m_count = (m_count + (up ? 1 : 15)) % 16;
`endif
    endfunction

    // One arbitrated operation, checked every cycle from grant to idle.
    task automatic txn(input bit ra, input bit rb,
                       input logic [1:0] oa, input logic [3:0] va,
                       input logic [1:0] ob, input logic [3:0] vb,
                       input bit noise);
        bit         win;
        logic [1:0] op;
        int         v;
        int         dur;
        req_a = ra; req_b = rb;
        op_a = oa; val_a = va; op_b = ob; val_b = vb;
        win    = rb && (!ra || m_last == 0);
        op     = win ? ob : oa;
        v      = win ? int'(vb) : int'(va);
        m_last = win;
        dur    = (op == OP_LOAD || op == OP_CLEAR) ? 2 : v + 2;
        tick;
        chk("gnt_a_c1", gnt_a, !win);
        chk("gnt_b_c1", gnt_b, win);
        chk("owner_c1", owner, win);
        chk("busy_c1", busy, 1);
        chk("done_c1", done, 0);
        chk("count_c1", count, m_count);
        req_a = 0; req_b = 0;
        for (int c = 2; c <= dur; c++) begin
            if (noise) begin
                req_a = 1'($urandom_range(0, 1));
                req_b = 1'($urandom_range(0, 1));
                op_a  = 2'($urandom);
                op_b  = 2'($urandom);
                val_a = 4'($urandom);
                val_b = 4'($urandom);
            end
            tick;
            if (c == 2 && op == OP_LOAD) begin
                m_count = v;
            end else if (c == 2 && op == OP_CLEAR) begin
                m_count = 0;
                m_ovf   = 0;
            end else if ((op == OP_UP || op == OP_DOWN) && c <= v + 1) begin
                m_step(op == OP_UP);
            end
            chk("count", count, m_count);
            chk("done", done, (c == dur));
            chk("busy", busy, 1);
            chk("gnt_idle", {gnt_a, gnt_b}, 0);
            chk("owner", owner, win);
            chk("ovf", ovf, m_ovf);
        end
        req_a = 0; req_b = 0;
        tick;
        chk("busy_end", busy, 0);
        chk("done_end", done, 0);
        chk("count_end", count, m_count);
        chk("gnt_end", {gnt_a, gnt_b}, 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_count"}, count, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_gnt"}, {gnt_a, gnt_b}, 0);
        chk({tag, "_owner"}, owner, 0);
        chk({tag, "_ovf"}, ovf, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("rst");
        clr_n = 1'b1;

        // A LOAD 7
        txn(1, 0, OP_LOAD, 4'd7, OP_LOAD, 4'd0, 0);
        // count 14, then B UP 3 across the wrap point
        txn(1, 0, OP_LOAD, 4'd14, OP_LOAD, 4'd0, 0);
        txn(0, 1, OP_LOAD, 4'd0, OP_UP, 4'd3, 1);
        // two ties in a row; previous grant was B, so A then B
        txn(1, 1, OP_LOAD, 4'd3, OP_LOAD, 4'd9, 0);
        txn(1, 1, OP_UP, 4'd2, OP_DOWN, 4'd1, 0);
        // DOWN 0 leaves count alone; DOWN 2 from 1 wraps
        txn(1, 0, OP_LOAD, 4'd5, OP_LOAD, 4'd0, 0);
        txn(1, 0, OP_DOWN, 4'd0, OP_LOAD, 4'd0, 0);
        txn(0, 1, OP_LOAD, 4'd0, OP_LOAD, 4'd1, 0);
        txn(0, 1, OP_LOAD, 4'd0, OP_DOWN, 4'd2, 0);
        txn(1, 0, OP_CLEAR, 4'd6, OP_LOAD, 4'd0, 1);

        // Reset mid-way through UP 10
        txn(1, 0, OP_LOAD, 4'd4, OP_LOAD, 4'd0, 0);
        req_a = 1; op_a = OP_UP; val_a = 4'd10;
        tick;
        req_a = 0;
        tick;
        tick;
        #2;
        clr_n = 1'b0;
        #1;
        chk_reset_state("midrst");
        @(posedge clk);
        #1;
        clr_n   = 1'b1;
        m_count = 0;
        m_last  = 1;
        m_ovf   = 0;
        tick;
        chk_reset_state("postrst");
        txn(1, 1, OP_LOAD, 4'd11, OP_LOAD, 4'd2, 0);

        // Randomized operations with random request patterns
        for (int i = 0; i < 40; i++) begin
            bit ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1;
            txn(ra, rb, 2'($urandom), 4'($urandom), 2'($urandom), 4'($urandom),
                1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cnt_arb_ctrl
`default_nettype wire

// File: doc/cnt_arb_ctrl.md
CNT_ARB_CTRL -- requirements
Module: cnt_arb_ctrl

Interface
REQ-001 SHALL have these ports (clock and reset first):
- clk  in  1  single clock; all state changes on its rising edge.
- clr_n  in  1  reset, asynchronous assert, active-low.
- req_a, req_b  in  1  operation request from requester A / B.
- op_a, op_b  in  2  opcode: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- val_a, val_b  in  4  LOAD data, or UP/DOWN step count.
- gnt_a, gnt_b  out  1  one-cycle grant pulse.
- done  out  1  one-cycle completion pulse.
- owner  out  1  requester of the current/last operation (0 = A, 1 = B).
- busy  out  1  high when the state is not IDLE.
- count  out  4  shared counter value.
- ovf  out  1  sticky saturation flag (CNT_ARB_SAT_EN builds only; constant 0 otherwise).

Function
REQ-002 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-003 In IDLE, with req_a or req_b high at an edge, SHALL latch the winner's op/val into op_q/rem, set owner, pulse that gnt for the next cycle, and go to EXEC.
REQ-004 Arbitration SHALL be round-robin: on simultaneous requests, grant the requester not granted last; after reset, A wins the first tie.
REQ-005 Requests outside IDLE SHALL be ignored; a requester SHALL hold req until its gnt (gnt_a and gnt_b never high together).
REQ-006 In EXEC, LOAD and CLEAR SHALL each take one EXEC cycle: count <= val (LOAD) or 0 (CLEAR), then go to DONE.
REQ-007 In EXEC, UP/DOWN with rem != 0 SHALL apply count +/- 1 and rem - 1 each cycle; with rem == 0 SHALL go to DONE with count unchanged.
REQ-008 UP/DOWN by k SHALL take k+1 EXEC cycles; val = 0 SHALL complete with count unchanged.
REQ-009 Timing, with the request sampled at edge 0: gnt high in cycle 1; done high in cycle 2 (LOAD/CLEAR) or cycle k+2 (UP/DOWN by k); busy low again in the cycle after done.
REQ-010 done SHALL be high for exactly the one cycle spent in DONE; DONE always returns to IDLE.
REQ-011 Arithmetic SHALL be modulo 16 (15+1 -> 0, 0-1 -> 15) unless CNT_ARB_SAT_EN is defined.
REQ-012 count SHALL change only in EXEC.

Reset
REQ-013 clr_n low SHALL immediately force state IDLE, count 0, rem 0, gnt_a/gnt_b/done/busy/owner/ovf 0, and round-robin pointer "last = B".
REQ-014 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-015 The first request SHALL be sampled no earlier than the first edge after clr_n deasserts.

Configuration
REQ-016 Macro CNT_ARB_SAT_EN defined: UP SHALL hold at 15 and DOWN SHALL hold at 0.
REQ-017 With CNT_ARB_SAT_EN, each step that would wrap SHALL instead set ovf, and rem SHALL still decrement on that step.
REQ-018 With CNT_ARB_SAT_EN, ovf SHALL clear only on reset or on completion of a CLEAR operation.
REQ-019 Macro CNT_ARB_SAT_EN undefined: count SHALL wrap per REQ-011 and ovf SHALL be tied to 0.

Structure
REQ-020 Shared package cnt_arb_pkg SHALL hold the opcode constants (OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR), the FSM state encoding, and CNT_W = 4.
REQ-021 The counter SHALL be a sub-module cnt_core with ports clk, clr_n, sclr, load, en, up, din, count, driven by the FSM.

Verification
REQ-022 Reset, then A LOAD 7 -> gnt_a in cycle 1; count = 7 and done in cycle 2; owner = 0.
REQ-023 count = 14, B UP 3 -> count 15, 0, 1 over successive EXEC cycles; done in cycle 5. With CNT_ARB_SAT_EN: 15, 15, 15 and ovf = 1.
REQ-024 req_a and req_b raised together, twice in succession -> first gnt_a, then gnt_b.
REQ-025 A DOWN 0 at count 5 -> done in cycle 2, count stays 5; B DOWN 2 at count 1 -> count ends at 15 (wrap build).
REQ-026 clr_n pulsed low during UP 10 -> count 0, busy 0 and no done; next request is accepted normally.
